// File: rtl/cla_multiword_add_seq.sv
// cla_multiword_add_seq: WORDS x 32-bit add/subtract sequenced over one 32-bit CLA
// Ports:
//   clk_i, rst_ni                 clock, synchronous active-low reset
//   req_valid_i / req_ready_o     operand handshake (ready only in IDLE)
//   a_i, b_i, cin_i, sub_i        operands, carry-in (add only), subtract select
//   res_valid_o / res_ready_i     result handshake
//   sum_o, cout_o, ovf_o          result, carry out of MSB, signed overflow
//   busy_o                        high while an operation is running or held
module cla_adder_32bit (
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic        c_i,
    output logic [31:0] s_o,
    output logic        c_o,
    output logic        P_o,
    output logic        G_o
);
    logic [31:0] w_p, w_g, w_c;
    logic [7:0]  w_gp, w_gg;
    logic [8:0]  w_gc, w_gacc;
    assign w_p       = a_i ^ b_i;
    assign w_g       = a_i & b_i;
    assign w_gc[0]   = c_i;
    assign w_gacc[0] = 1'b0;
    for (genvar j = 0; j < 8; j++) begin : g_grp
        localparam int K = 4 * j;
        assign w_c[K]   = w_gc[j];
        assign w_c[K+1] = w_g[K] | (w_p[K] & w_gc[j]);
        assign w_c[K+2] = w_g[K+1] | (w_p[K+1] & w_g[K]) | (w_p[K+1] & w_p[K] & w_gc[j]);
        assign w_c[K+3] = w_g[K+2] | (w_p[K+2] & w_g[K+1]) | (w_p[K+2] & w_p[K+1] & w_g[K])
                        | (w_p[K+2] & w_p[K+1] & w_p[K] & w_gc[j]);
        assign w_gp[j]  = &w_p[K+:4];
        assign w_gg[j]  = w_g[K+3] | (w_p[K+3] & w_g[K+2]) | (w_p[K+3] & w_p[K+2] & w_g[K+1])
                        | (w_p[K+3] & w_p[K+2] & w_p[K+1] & w_g[K]);
        // group-level lookahead: carry into the next nibble from group P/G
        assign w_gc[j+1]   = w_gg[j] | (w_gp[j] & w_gc[j]);
        assign w_gacc[j+1] = w_gg[j] | (w_gp[j] & w_gacc[j]);
    end
    assign s_o = w_p ^ w_c;
    assign c_o = w_gc[8];
    assign P_o = &w_gp;
    assign G_o = w_gacc[8];
endmodule

module cla_multiword_add_seq #(
    parameter int WORDS = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic [32*WORDS-1:0]  a_i,
    input  logic [32*WORDS-1:0]  b_i,
    input  logic                 cin_i,
    input  logic                 sub_i,
    output logic                 res_valid_o,
    input  logic                 res_ready_i,
    output logic [32*WORDS-1:0]  sum_o,
    output logic                 cout_o,
    output logic                 ovf_o,
    output logic                 busy_o
);
    localparam int IW = $clog2(WORDS);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t              r_state;
    logic [32*WORDS-1:0] r_a, r_b, r_sum;
    logic                r_carry, r_cout, r_ovf, r_ready, r_valid, r_busy;
    logic [IW-1:0]       r_idx;
    logic [31:0]         w_a, w_b, w_s;
    logic                w_cout, w_unused_p, w_unused_g;
    assign w_a = r_a[32*r_idx +: 32];
    assign w_b = r_b[32*r_idx +: 32];
    cla_adder_32bit u_cla (
        .a_i (w_a),
        .b_i (w_b),
        .c_i (r_carry),
        .s_o (w_s),
        .c_o (w_cout),
        .P_o (w_unused_p),
        .G_o (w_unused_g)
    );
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state <= IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
            r_idx   <= '0;
            r_ready <= 1'b1;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (req_valid_i) begin
                    r_a     <= a_i;
                    r_b     <= sub_i ? ~b_i : b_i;
                    r_carry <= sub_i | cin_i;
                    r_idx   <= '0;
                    r_ready <= 1'b0;
                    r_busy  <= 1'b1;
                    r_state <= RUN;
                end
                RUN: begin
                    r_sum[32*r_idx +: 32] <= w_s;
                    r_carry <= w_cout;
                    if (r_idx == IW'(WORDS - 1)) begin
                        // carry into the MSB is a^b^s there; overflow is that xor carry out
                        r_cout  <= w_cout;
                        r_ovf   <= w_cout ^ (w_a[31] ^ w_b[31] ^ w_s[31]);
                        r_valid <= 1'b1;
                        r_state <= DONE;
                    end else begin
                        r_idx <= r_idx + IW'(1);
                    end
                end
                DONE: if (res_ready_i) begin
                    r_valid <= 1'b0;
                    r_busy  <= 1'b0;
                    r_ready <= 1'b1;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
    assign req_ready_o = r_ready;
    assign res_valid_o = r_valid;
    assign busy_o      = r_busy;
    assign sum_o       = r_sum;
    assign cout_o      = r_cout;
    assign ovf_o       = r_ovf;
endmodule

// File: tb/tb_cla_multiword_add_seq.sv
// tb_cla_multiword_add_seq: directed and random checks of the 4-word add/sub sequencer
module tb_cla_multiword_add_seq;
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         req_valid = 1'b0, req_ready, cin = 1'b0, sub = 1'b0;
    logic [127:0] a = '0, b = '0, sum;
    logic         res_valid, res_ready = 1'b0, cout, ovf, busy;
    int           checks = 0, errors = 0, cyc = 0;
    cla_multiword_add_seq #(.WORDS(4)) dut (
        .clk_i(clk), .rst_ni(rst_n), .req_valid_i(req_valid), .req_ready_o(req_ready),
        .a_i(a), .b_i(b), .cin_i(cin), .sub_i(sub), .res_valid_o(res_valid),
        .res_ready_i(res_ready), .sum_o(sum), .cout_o(cout), .ovf_o(ovf), .busy_o(busy)
    );
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    function automatic void model(input logic [127:0] x, y, input logic c, s,
                                  output logic [127:0] r, output logic co, ov);
        logic [128:0] u;
        logic [129:0] sx, sy, sr;
        sx = {{2{x[127]}}, x};
        sy = {{2{y[127]}}, y};
        if (s) begin
            u  = {1'b0, x} - {1'b0, y};
            co = (x >= y);
            sr = sx - sy;
        end else begin
            u  = {1'b0, x} + {1'b0, y} + 129'(c);
            co = u[128];
            sr = sx + sy + 130'(c);
        end
        r  = u[127:0];
        ov = (sr[128] != sr[127]);
    endfunction
    task automatic chk_reset(input string tag);
        chk({tag, "_ready"}, 128'(req_ready), 128'd1);
        chk({tag, "_valid"}, 128'(res_valid), 128'd0);
        chk({tag, "_busy"}, 128'(busy), 128'd0);
        chk({tag, "_sum"}, sum, 128'd0);
        chk({tag, "_cout"}, 128'(cout), 128'd0);
        chk({tag, "_ovf"}, 128'(ovf), 128'd0);
    endtask
    task automatic accept(input logic [127:0] x, y, input logic c, s);
        int n = 0;
        while (!req_ready && n < 20) begin step(); n++; end
        chk("req_ready_wait", 128'(req_ready), 128'd1);
        a = x; b = y; cin = c; sub = s; req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        a = {$urandom, $urandom, $urandom, $urandom};
        b = {$urandom, $urandom, $urandom, $urandom};
        cin = 1'($urandom); sub = 1'($urandom);
        chk("busy_after_accept", 128'(busy), 128'd1);
    endtask
    task automatic do_op(input string tag, input logic [127:0] x, y, input logic c, s, input int hold);
        logic [127:0] er, held;
        logic eco, eov;
        int lat = 0;
        model(x, y, c, s, er, eco, eov);
        accept(x, y, c, s);
        while (!res_valid && lat < 20) begin step(); lat++; end
        chk({tag, "_latency"}, 128'(lat), 128'd4);
        chk({tag, "_sum"}, sum, er);
        chk({tag, "_cout"}, 128'(cout), 128'(eco));
        chk({tag, "_ovf"}, 128'(ovf), 128'(eov));
        held = sum;
        for (int i = 0; i < hold; i++) begin
            req_valid = 1'($urandom);
            a = {$urandom, $urandom, $urandom, $urandom};
            step();
            chk({tag, "_hold_valid"}, 128'(res_valid), 128'd1);
            chk({tag, "_hold_sum"}, sum, held);
            chk({tag, "_hold_ready"}, 128'(req_ready), 128'd0);
        end
        req_valid = 1'b0;
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        chk({tag, "_idle_valid"}, 128'(res_valid), 128'd0);
        chk({tag, "_idle_ready"}, 128'(req_ready), 128'd1);
        chk({tag, "_idle_busy"}, 128'(busy), 128'd0);
    endtask
    initial begin
        logic [127:0] ra, rb;
        int t0, n;
        bit rose;
        step();
        step();
        chk_reset("reset");
        rst_n = 1'b1;
        step();
        do_op("ripple", '1, 128'd1, 1'b0, 1'b0, 0);
        do_op("borrow", '0, 128'd1, 1'b1, 1'b1, 0);
        do_op("sovf", {1'b0, {127{1'b1}}}, 128'd1, 1'b0, 1'b0, 0);
        do_op("sub_min", 128'd0, {1'b1, 127'd0}, 1'b0, 1'b1, 0);
        do_op("sub_eq", 128'h1234, 128'h1234, 1'b0, 1'b1, 0);
        do_op("backpressure", 128'hDEAD_BEEF_0000_0001, 128'hFFFF_FFFF, 1'b1, 1'b0, 10);
        accept(128'd3, 128'd4, 1'b0, 1'b0);
        chk("after_bp_accept_ready", 128'(req_ready), 128'd0);
        n = 0;
        while (!res_valid && n < 20) begin step(); n++; end
        chk("after_bp_sum", sum, 128'd7);
        res_ready = 1'b1;
        req_valid = 1'b1;
        a = 128'd10; b = 128'd20; cin = 1'b0; sub = 1'b0;
        n = 0;
        while (!req_ready && n < 20) begin step(); n++; end
        step();
        t0 = cyc;
        a = 128'd1; b = 128'd2;
        n = 0;
        while (!req_ready && n < 20) begin step(); n++; end
        step();
        chk("throughput_period", 128'(cyc - t0), 128'd6);
        chk("throughput_busy", 128'(busy), 128'd1);
        req_valid = 1'b0;
        n = 0;
        while (!res_valid && n < 20) begin step(); n++; end
        chk("throughput_sum", sum, 128'd3);
        step();
        res_ready = 1'b0;
        accept(128'd100, 128'd200, 1'b0, 1'b0);
        step();
        rst_n = 1'b0;
        step();
        chk_reset("midreset");
        step();
        rst_n = 1'b1;
        rose = 1'b0;
        for (int i = 0; i < 8; i++) begin step(); rose |= res_valid; end
        chk("midreset_no_result", 128'(rose), 128'd0);
        do_op("after_reset", 128'd5, 128'd7, 1'b0, 1'b0, 0);
        for (int i = 0; i < 24; i++) begin
            ra = {$urandom, $urandom, $urandom, $urandom};
            rb = (i % 4 == 0) ? ~ra : {$urandom, $urandom, $urandom, $urandom};
            do_op("random", ra, rb, 1'($urandom), 1'($urandom), int'($urandom_range(0, 3)));
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
